striping: RTL

//  Transmit-side byte-striping stage: the inverse of un_striping.
//  - Takes one 32-bit word stream (data_in/valid_in) at the clk_2f rate.
//  - Deals the words alternately onto two lanes (lane_0, lane_1), each holding a word for two clk_2f cycles.
//  - Sits in front of the per-lane serializers; its lane_0/lane_1/valid_0/valid_1 outputs feed un_striping directly in loopback benches.

---
 rtl/striping.sv | 72 +++++++
 1 files changed

// File: rtl/striping.sv
// Transmit-side byte striping: deals one word stream alternately onto two lanes,
// each lane word held for two clk_2f cycles so the lanes run at the clk_f rate.
module striping #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] lane_0,
  output logic             valid_0,
  output logic [WIDTH-1:0] lane_1,
  output logic             valid_1,
  output logic             lane_sel,
  output logic [CNT_W-1:0] word_count
);

  logic [WIDTH-1:0] lane_0_r;
  logic [WIDTH-1:0] lane_1_r;
  logic             valid_0_r;
  logic             valid_1_r;
  logic             sel_r;
  logic [CNT_W-1:0] count_r;

  logic [WIDTH-1:0] slot_data_s;
  logic [CNT_W-1:0] count_next_s;

  // Next slot contents and counter value; idle slots carry an all-zero word
  always_comb begin
    slot_data_s  = {WIDTH{1'b0}};
    count_next_s = count_r;
    if (valid_in) begin
      slot_data_s  = data_in;
      count_next_s = count_r + CNT_W'(1);
    end else begin
      slot_data_s  = {WIDTH{1'b0}};
      count_next_s = count_r;
    end
  end

  // Lane registers, free-running selector and word counter
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      lane_0_r  <= {WIDTH{1'b0}};
      lane_1_r  <= {WIDTH{1'b0}};
      valid_0_r <= 1'b0;
      valid_1_r <= 1'b0;
      sel_r     <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
    end else begin
      // Selector toggles every edge so idle cycles still consume a slot
      sel_r   <= ~sel_r;
      count_r <= count_next_s;
      if (sel_r == 1'b0) begin
        lane_0_r  <= slot_data_s;
        valid_0_r <= valid_in;
      end else begin
        lane_1_r  <= slot_data_s;
        valid_1_r <= valid_in;
      end
    end
  end

  assign lane_0     = lane_0_r;
  assign valid_0    = valid_0_r;
  assign lane_1     = lane_1_r;
  assign valid_1    = valid_1_r;
  assign lane_sel   = sel_r;
  assign word_count = count_r;

endmodule
